// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_pkg
// Brief    : Shared types and the immediate-format decoder for imm_gen_stage.
// Revision : 1.0 - initial release
// ============================================================================
package imm_pkg;

    // Widest immediate any configuration can ask for; callers take the low
    // DATA_WIDTH bits, which is still a correct sign extension.
    localparam int c_IMM_MAX_W = 64;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_B = 3'd1,
        IMM_S = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_e;

    // Max-width view of one buffered entry.
    typedef struct packed {
        logic [c_IMM_MAX_W-1:0] imm;
        logic [c_IMM_MAX_W-1:0] target;
        logic [c_IMM_MAX_W-1:0] pc;
        logic                   illegal;
    } imm_entry_t;

    // Sign bit is always instr[31]; reserved encodings yield zero.
    function automatic logic [c_IMM_MAX_W-1:0] imm_decode(input logic [31:0] instr,
                                                           input imm_src_e    src);
        logic [c_IMM_MAX_W-1:0] imm;
        case (src)
            IMM_I:   imm = {{52{instr[31]}}, instr[31:20]};
            IMM_B:   imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_U:   imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            IMM_J:   imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    function automatic logic imm_is_reserved(input logic [2:0] src);
        return (src > 3'd4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : imm_skid_buf
// Brief    : 2-entry valid/ready buffer (head + skid) with synchronous flush.
//            in_ready depends only on registered state.
// Revision : 1.0 - initial release
// ============================================================================
module imm_skid_buf
    import imm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             head_valid_q, head_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             w_push;
    logic             w_pop;

    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = head_valid_q;
    assign out_data_o  = head_q;

    assign w_push = in_valid_i && !skid_valid_q;
    assign w_pop  = head_valid_q && out_ready_i;

    // Next-state: data registers only move on an actual load.
    always_comb begin
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        head_d       = head_q;
        skid_d       = skid_q;
        if (flush_i) begin
            // Pop in this cycle counts as consumed; any push is dropped.
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (w_pop) begin
            if (skid_valid_q) begin
                // No push possible here: in_ready is low while skid is full.
                head_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (w_push) begin
                head_d = in_data_i;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (w_push) begin
            if (head_valid_q) begin
                skid_d       = in_data_i;
                skid_valid_d = 1'b1;
            end else begin
                head_d       = in_data_i;
                head_valid_d = 1'b1;
            end
        end
    end

    // State register; async reset clears data too so outputs read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            head_q       <= '0;
            skid_q       <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            head_q       <= head_d;
            skid_q       <= skid_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_stage
// Brief    : Decode-stage immediate generator: format decode, sign extension,
//            PC + imm target, registered behind a 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [ADDR_WIDTH-1:0]  pc,
    input  logic [2:0]             ImmSrc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  ImmOp,
    output logic [ADDR_WIDTH-1:0]  PCTarget,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic                   imm_illegal
);

    localparam int c_PAYLOAD_W = DATA_WIDTH + 2 * ADDR_WIDTH + 1;

    if (INSTR_WIDTH != 32) begin : g_chk_instr_w
        $error("imm_gen_stage: INSTR_WIDTH must be 32");
    end
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_chk_data_w
        $error("imm_gen_stage: DATA_WIDTH must be 32 or 64");
    end
    if (ADDR_WIDTH > DATA_WIDTH) begin : g_chk_addr_w
        $error("imm_gen_stage: ADDR_WIDTH must not exceed DATA_WIDTH");
    end

    logic [c_IMM_MAX_W-1:0] w_imm_full;
    logic [DATA_WIDTH-1:0]  w_imm;
    logic [ADDR_WIDTH-1:0]  w_target;
    logic                   w_illegal;
    logic [c_PAYLOAD_W-1:0] w_in_data;
    logic [c_PAYLOAD_W-1:0] w_out_data;
    logic [6:0]             w_unused_opcode;

    // Opcode bits never contribute to an immediate.
    assign w_unused_opcode = instr[6:0];

    assign w_imm_full = imm_decode(instr[31:0], imm_src_e'(ImmSrc));
    assign w_imm      = w_imm_full[DATA_WIDTH-1:0];
    assign w_illegal  = imm_is_reserved(ImmSrc);

    if (DATA_WIDTH < c_IMM_MAX_W) begin : g_imm_hi
        logic [c_IMM_MAX_W-DATA_WIDTH-1:0] w_unused_imm_hi;
        assign w_unused_imm_hi = w_imm_full[c_IMM_MAX_W-1:DATA_WIDTH];
    end

    // Target wraps modulo 2^ADDR_WIDTH without any flag.
    assign w_target = pc + w_imm[ADDR_WIDTH-1:0];

    assign w_in_data = {w_illegal, pc, w_target, w_imm};

    imm_skid_buf #(
        .WIDTH (c_PAYLOAD_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (w_in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (w_out_data)
    );

    assign {imm_illegal, out_pc, PCTarget, ImmOp} = w_out_data;

endmodule
`default_nettype wire

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Pipelined, parametrised immediate generator for the decode stage of the RISC-V core.
- Decodes all base immediate formats (I, B, S, U, J) and sign-extends them to DATA_WIDTH.
- Computes the branch/jump target PC + imm.
- Registers the results behind a valid/ready handshake with a 2-entry skid buffer and a synchronous flush, so decode can stall or squash without losing or duplicating instructions.

Parameters:
- INSTR_WIDTH, 32, instruction width; fixed at 32, elaboration error otherwise.
- DATA_WIDTH, 32, width of the sign-extended immediate; must be >= 32 (32 or 64).
- ADDR_WIDTH, 32, PC width; must be <= DATA_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all buffered entries.
- in_valid  in  1  upstream presents instr/pc/ImmSrc.
- in_ready  out  1  stage can accept this cycle.
- instr  in  INSTR_WIDTH  fetched instruction.
- pc  in  ADDR_WIDTH  PC of instr.
- ImmSrc  in  3  format select: 0=I, 1=B, 2=S, 3=U, 4=J, 5-7 reserved.
- out_valid  out  1  ImmOp/PCTarget valid.
- out_ready  in  1  downstream accepts.
- ImmOp  out  DATA_WIDTH  sign-extended immediate.
- PCTarget  out  ADDR_WIDTH  pc + ImmOp[ADDR_WIDTH-1:0].
- out_pc  out  ADDR_WIDTH  pc of the entry at the head.
- imm_illegal  out  1  entry was decoded with a reserved ImmSrc.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: out_valid=0, ImmOp=0, PCTarget=0, out_pc=0, imm_illegal=0, buffer empty. in_ready=1 in the first cycle after rst deasserts.
- Format decode (combinational on input, extension bit is instr[31]):
  - I: instr[31:20]
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
  - S: {instr[31:25], instr[11:7]}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
  - All formats sign-extend to DATA_WIDTH.
  - Reserved ImmSrc: ImmOp=0, imm_illegal=1.
- Target: PCTarget = pc + ImmOp[ADDR_WIDTH-1:0], modulo 2^ADDR_WIDTH. Wrap-around is silent, no flag. Computed before registering.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - Latency 1 cycle: an entry accepted at edge N is visible on the outputs after edge N (out_valid=1), if the buffer was empty.
  - Buffer is a 2-entry FIFO: head drives the outputs, skid holds the overflow.
  - in_ready = !(skid occupied), i.e. registered, not combinationally dependent on out_ready.
  - Buffer empty: out_valid=0.
  - Push with head empty: written to head.
  - Push with head full and no pop: written to skid; in_ready drops next cycle.
  - Simultaneous push and pop with one entry: new entry to head, count stays 1.
  - Simultaneous push and pop with two entries: impossible, since in_ready=0.
  - Pop with skid occupied: skid moves to head, in_ready=1 next cycle.
  - Order is strictly preserved.
  - Output fields are stable while out_valid && !out_ready.
- Flush:
  - Empties both entries at the edge; out_valid=0 the next cycle.
  - An input handshake in the flush cycle is dropped.
  - A downstream pop in the flush cycle is still counted as consumed.
  - in_ready=1 in the cycle after flush.
- Reset mid-operation: all entries discarded immediately (async), outputs go to reset values.
- Data registers change only on a load, so no X propagation from idle inputs.

Decomposition:
- Shared package imm_pkg:
  - typedef enum logic [2:0] imm_src_e {IMM_I=0, IMM_B=1, IMM_S=2, IMM_U=3, IMM_J=4}.
  - Struct imm_entry_t {imm, target, pc, illegal}.
  - Function imm_decode(instr, src) returning the DATA_WIDTH immediate.
- Sub-module imm_skid_buf: a 2-entry, parametrised-payload valid/ready buffer with flush. imm_gen_stage = decode/adder + imm_skid_buf.

Test Plan:
- I and S decode:
  - instr=0xFFF00093, ImmSrc=0, pc=0x0 -> next cycle ImmOp=0xFFFFFFFF, PCTarget=0xFFFFFFFF, imm_illegal=0.
  - instr=0xFE512C23 (sw x5,-8(x2)), ImmSrc=2 -> ImmOp=0xFFFFFFF8.
- B-type target: instr=0xFE000EE3 (beq -4), ImmSrc=1, pc=0x100 -> ImmOp=0xFFFFFFFC, PCTarget=0x000000FC.
- U and J decode:
  - instr=0x123452B7, ImmSrc=3 -> ImmOp=0x12345000.
  - instr=0x001000EF, ImmSrc=4, pc=0x1000 -> ImmOp=0x00000800, PCTarget=0x1800.
  - Repeat with DATA_WIDTH=64: ImmOp=0xFFFFFFFFFFFFFFFF for the first I case.
- Backpressure: out_ready=0, push A(pc=0x10), B(pc=0x14) on consecutive cycles -> in_ready=0 after B. Raise out_ready -> out_pc 0x10 then 0x14, no duplicates, in_ready=1 after the first pop.
- Flush/reserved:
  - Buffer full, flush=1 with in_valid=1 -> out_valid=0 next cycle, the incoming entry is not seen.
  - ImmSrc=7 -> ImmOp=0, imm_illegal=1.
- Reset mid-operation: two entries held, assert rst asynchronously between edges -> out_valid=0 and ImmOp=0 immediately. After release, in_ready=1 and the first new push appears after 1 cycle.
